// File: rtl/rip_fetch_pkg.sv
// rip_fetch_pkg: shared types and constants for the instruction-fetch stage
package rip_fetch_pkg;
  localparam int PC_W = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} FETCH_STATE_T;
endpackage

// File: rtl/rip_fetch_if.sv
// rip_fetch_if: imem request/response and decode-side signals of the fetch stage
interface rip_fetch_if;
  import rip_fetch_pkg::*;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            ex_stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [31:0]     inst_code;
  logic            de_ready;
  logic [PC_W-1:0] if_pc;
  logic [PC_W-1:0] de_pc;
  modport master (
    output imem_req_valid, imem_addr, inst_code, de_ready, if_pc, de_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, ex_stall, redirect, redirect_pc
  );
  modport slave (
    input  imem_req_valid, imem_addr, inst_code, de_ready, if_pc, de_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, ex_stall, redirect, redirect_pc
  );
endinterface

// File: rtl/rip_fetch_queue.sv
// rip_fetch_queue: synchronous FIFO with push/pop/flush, empty/full and occupancy count
module rip_fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;
  assign o_empty = r_count == '0;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_data;
  end
  // pointers and occupancy; flush empties the queue in one cycle
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= w_push ? r_wr + AW'(1) : r_wr;
      r_rd    <= w_pop ? r_rd + AW'(1) : r_rd;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/rip_fetch.sv
// rip_fetch: PC, in-order imem requests, prefetch queue and redirect drain (optional RIP_FETCH_PERF_EN bubble counter)
module rip_fetch
  import rip_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int              QUEUE_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  rip_fetch_if.master       bus
`ifdef RIP_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_bubble_cnt
`endif
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);
  FETCH_STATE_T       r_state;
  FETCH_STATE_T       w_state_nxt;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_de_pc;
  logic [CW-1:0]      r_discard;
  logic [CW-1:0]      w_discard_nxt;
  logic [CW-1:0]      w_q_count;
  logic [CW-1:0]      w_t_count;
  logic [CW:0]        w_sum;
  logic               w_q_empty;
  logic               w_q_full;
  logic               w_t_empty;
  logic               w_t_full;
  logic [PC_W+31:0]   w_q_data;
  logic [PC_W-1:0]    w_tag;
  logic               w_rsp;
  logic               w_push;
  logic               w_req_fire;
  // a response with no tag pending is stray (e.g. after a mid-flight reset) and is ignored
  assign w_rsp      = bus.imem_rsp_valid && !w_t_empty;
  assign w_push     = w_rsp && r_discard == '0 && !bus.redirect;
  assign w_sum      = {1'b0, w_t_count} + {1'b0, w_q_count};
  assign bus.imem_req_valid = r_state != BOOT && !bus.redirect && w_sum < DEPTH_W && !w_t_full && !w_q_full;
  assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign bus.imem_addr = r_pc;
  assign bus.de_ready  = !w_q_empty && !bus.ex_stall && !bus.redirect;
  assign bus.inst_code = w_q_empty ? '0 : w_q_data[31:0];
  assign bus.if_pc     = w_q_empty ? '0 : w_q_data[PC_W+31:32];
  assign bus.de_pc     = r_de_pc;
  rip_fetch_queue #(.WIDTH(PC_W + 32), .DEPTH(QUEUE_DEPTH)) u_inst_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (bus.de_ready),
    .i_flush (bus.redirect),
    .i_data  ({w_tag, bus.imem_rsp_data}),
    .o_data  (w_q_data),
    .o_empty (w_q_empty),
    .o_full  (w_q_full),
    .o_count (w_q_count)
  );
  // the tag FIFO tracks every in-flight request, so its count is the outstanding count;
  // it is never flushed because dropped responses must still retire their tags
  rip_fetch_queue #(.WIDTH(PC_W), .DEPTH(QUEUE_DEPTH)) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_req_fire),
    .i_pop   (w_rsp),
    .i_flush (1'b0),
    .i_data  (r_pc),
    .o_data  (w_tag),
    .o_empty (w_t_empty),
    .o_full  (w_t_full),
    .o_count (w_t_count)
  );
  // next state and discard count; a redirect drops everything still in flight after this cycle's response
  always_comb begin
    w_discard_nxt = (w_rsp && r_discard != '0) ? r_discard - CW'(1) : r_discard;
    w_discard_nxt = bus.redirect ? w_t_count - CW'(w_rsp) : w_discard_nxt;
    w_state_nxt   = (r_state == BOOT) ? RUN : (w_discard_nxt != '0 ? DRAIN : RUN);
  end
  // state, PC and decode-aligned PC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= BOOT;
      r_pc      <= RESET_PC;
      r_discard <= '0;
      r_de_pc   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
      r_pc      <= bus.redirect ? {bus.redirect_pc[PC_W-1:2], 2'b00} : w_req_fire ? r_pc + 32'd4 : r_pc;
      r_de_pc   <= bus.de_ready ? bus.if_pc : !bus.ex_stall ? '0 : r_de_pc;
    end
  end
`ifdef RIP_FETCH_PERF_EN
  // saturating count of cycles where decode could take a word but the queue has none
  always_ff @(posedge clk) begin
    if (rst) perf_bubble_cnt <= '0;
    else if (w_q_empty && !bus.ex_stall && r_state != BOOT && perf_bubble_cnt != '1) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
  end
`endif
endmodule
